ac_exec_sequencer: RTL
======================

Name: ac_exec_sequencer

Overview:
- Multi-cycle execute-stage controller for the Basic Computer accumulator datapath.
- Accepts one decoded 16-bit instruction word at a time over a valid/ready handshake.
- Fetches operands from memory (direct or indirect), then sequences the shared accumulator ALU by driving its operand, op and E inputs.
- Owns the architectural AC, E and status flags; sits between the fetch unit and the memory port.

Parameters:
- W, 16, data/instruction width. Instruction layout: bit W-1 = I, bits W-2:W-4 = opcode, bits AW-1:0 = address.
- AW, 12, memory address width. Must satisfy AW <= W-4.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction word presented
- instr_ready  out  1  sequencer can accept; high only in IDLE and not halted
- instr  in  W  instruction word
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  AW  request address
- mem_wdata  out  W  write data (always AC)
- mem_rdata  in  W  read data, valid in the mem_ack cycle
- mem_ack  in  1  single-cycle completion strobe
- alu_ac  out  W  ALU AC operand (always AC register)
- alu_dr  out  W  ALU DR operand (DR register, or 1 for INC)
- alu_e_in  out  1  ALU E input (always E register)
- alu_op  out  3  ALU op code
- alu_out  in  W  ALU result
- alu_co, alu_ovf, alu_z, alu_n, alu_e_out  in  1 each  ALU status outputs
- ac  out  W  accumulator
- e  out  1  E flip-flop
- flag_z, flag_n, flag_c, flag_v  out  1 each  status latched on each AC write
- done  out  1  one-cycle pulse when an instruction retires
- skip  out  1  one-cycle pulse with done when a skip condition is true
- illegal  out  1  one-cycle pulse with done for an unsupported instruction
- halted  out  1  sticky; set by HLT

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - AC=0, DR=0, E=0, EA=0, all flags 0, halted=0, mem_req=0, mem_we=0, done/skip/illegal=0.
  - Any in-flight memory request is abandoned; the memory side must tolerate mem_req dropping.
- States: IDLE, IND, RD, EXEC, WR.
- IDLE:
  - instr_ready=1 unless halted.
  - On valid&ready, latch instr and set EA = instr[AW-1:0].
  - opcode 0..2 (AND/ADD/LDA) -> IND if I=1, else RD.
  - opcode 3 (STA) -> IND if I=1, else WR.
  - opcode 7 with I=0 (register-reference) -> EXEC.
  - opcode 4..6, or opcode 7 with I=1 -> pulse done+illegal in the next cycle, no state change, return to IDLE.
- IND: mem_req=1, we=0, addr=EA. On mem_ack: EA <= mem_rdata[AW-1:0], then go to RD (opcodes 0..2) or WR (STA).
- RD: mem_req=1, we=0, addr=EA. On mem_ack: DR <= mem_rdata, go to EXEC.
- WR: mem_req=1, we=1, addr=EA, wdata=AC. On the mem_ack cycle: pulse done, go to IDLE.
- Memory request rules:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1.
  - mem_req deasserts in the cycle after ack.
  - mem_ack with mem_req=0 is ignored.
  - No timeout.
- EXEC (one cycle, combinational use of the ALU):
  - AND: op=001. ADD: op=000. LDA: op=010.
  - Register-reference: exactly one action, chosen by the highest set bit of instr[11:0]; lower bits are ignored.
    - bit11 CLA: op=111 (result 0)
    - bit10 CLE: E <= 0, AC unchanged
    - bit9 CMA: op=011
    - bit8 CME: E <= ~E
    - bit7 CIR: op=100
    - bit6 CIL: op=101
    - bit5 INC: op=000 with alu_dr=1
    - bit4 SPA: skip if AC[W-1]=0
    - bit3 SNA: skip if AC[W-1]=1
    - bit2 SZA: skip if AC=0
    - bit1 SZE: skip if E=0
    - bit0 HLT: halted <= 1
    - instr[11:0]=0: no operation, done only.
  - On any ALU-writing op: AC <= alu_out, E <= alu_e_out, flag_z/n/c/v <= alu_z/n/co/ovf.
  - Ops that do not write AC leave the flags unchanged.
  - done pulses in the EXEC cycle's following edge, i.e. visible for one cycle after the update. skip and illegal are aligned with done.
  - Return to IDLE.
- Latency from the accept edge to done:
  - register-reference: 1 cycle.
  - direct memory-reference: 2 + ack wait.
  - indirect: adds one more memory transaction.
- Outside EXEC: alu_op=110 (transfer AC) and alu_dr=DR, so no spurious flag update can occur.
- halted: blocks further accepts. Only reset clears it.

Test Plan:
- Reset mid-RD (mem_req=1, no ack), then assert rst_n=0 -> mem_req=0 immediately; ac=0, e=0, instr_ready=1 after release.
- LDA direct 0x2010 with mem[0x010]=0x7FFF, then ADD 0x1011 with mem[0x011]=0x0001 -> ac=0x8000, flag_v=1, flag_n=1, flag_c=0, e=0.
- Indirect AND 0x8020 with mem[0x020]=0x0030 and mem[0x030]=0x00F0, AC=0x0FFF -> two reads (addr 0x020 then 0x030), ac=0x00F0, flag_z=0.
- STA 0x3040 with AC=0x1234 and mem_ack delayed 3 cycles -> mem_we=1, addr=0x040, wdata=0x1234 held stable all 4 cycles; done on the ack cycle.
- Register-reference 0x7C00 (CLA and CLE both set) -> only CLA executes: ac=0, flag_z=1, e unchanged. Then 0x7020 INC -> ac=0x0001. Then 0x7004 SZA -> skip=0.
- Opcode 5 instruction -> illegal=1 with done, ac unchanged. Then 0x7001 HLT -> halted=1, instr_ready stays 0 with instr_valid held high.

Source files
------------

// File: rtl/ac_exec_sequencer.sv
// Execute-stage sequencer for the Basic Computer accumulator datapath: operand
// fetch (direct or indirect), ALU sequencing, and architectural AC/E/flag state.
module ac_exec_sequencer #(
  parameter int W  = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [W-1:0]  instr,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  input  logic [W-1:0]  mem_rdata,
  input  logic          mem_ack,
  output logic [W-1:0]  alu_ac,
  output logic [W-1:0]  alu_dr,
  output logic          alu_e_in,
  output logic [2:0]    alu_op,
  input  logic [W-1:0]  alu_out,
  input  logic          alu_co,
  input  logic          alu_ovf,
  input  logic          alu_z,
  input  logic          alu_n,
  input  logic          alu_e_out,
  output logic [W-1:0]  ac,
  output logic          e,
  output logic          flag_z,
  output logic          flag_n,
  output logic          flag_c,
  output logic          flag_v,
  output logic          done,
  output logic          skip,
  output logic          illegal,
  output logic          halted
);

  localparam logic [2:0] OPC_AND = 3'd0;
  localparam logic [2:0] OPC_ADD = 3'd1;
  localparam logic [2:0] OPC_LDA = 3'd2;
  localparam logic [2:0] OPC_STA = 3'd3;
  localparam logic [2:0] OPC_REG = 3'd7;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_LDA  = 3'b010;
  localparam logic [2:0] ALU_CMA  = 3'b011;
  localparam logic [2:0] ALU_CIR  = 3'b100;
  localparam logic [2:0] ALU_CIL  = 3'b101;
  localparam logic [2:0] ALU_XFER = 3'b110;
  localparam logic [2:0] ALU_CLR  = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_IND, S_RD, S_EXEC, S_WR} state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  ir_reg, ir_next;
  logic [AW-1:0] ea_reg, ea_next;
  logic [W-1:0]  dr_reg, dr_next;
  logic [W-1:0]  ac_reg, ac_next;
  logic          e_reg, e_next;
  logic          z_reg, z_next, n_reg, n_next, c_reg, c_next, v_reg, v_next;
  logic          halted_reg, halted_next;
  logic          done_reg, done_next;
  logic          skip_reg, skip_next;
  logic          illegal_reg, illegal_next;
  logic          done_now;
  logic          dr_one;
  logic          alu_wr;

  logic [2:0] instr_opc;
  logic [2:0] ir_opc;
  assign instr_opc = instr[W-2:W-4];
  assign ir_opc    = ir_reg[W-2:W-4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      ir_reg      <= '0;
      ea_reg      <= '0;
      dr_reg      <= '0;
      ac_reg      <= '0;
      e_reg       <= 1'b0;
      z_reg       <= 1'b0;
      n_reg       <= 1'b0;
      c_reg       <= 1'b0;
      v_reg       <= 1'b0;
      halted_reg  <= 1'b0;
      done_reg    <= 1'b0;
      skip_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ir_reg      <= ir_next;
      ea_reg      <= ea_next;
      dr_reg      <= dr_next;
      ac_reg      <= ac_next;
      e_reg       <= e_next;
      z_reg       <= z_next;
      n_reg       <= n_next;
      c_reg       <= c_next;
      v_reg       <= v_next;
      halted_reg  <= halted_next;
      done_reg    <= done_next;
      skip_reg    <= skip_next;
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ir_next      = ir_reg;
    ea_next      = ea_reg;
    dr_next      = dr_reg;
    ac_next      = ac_reg;
    e_next       = e_reg;
    z_next       = z_reg;
    n_next       = n_reg;
    c_next       = c_reg;
    v_next       = v_reg;
    halted_next  = halted_reg;
    done_next    = 1'b0;
    skip_next    = 1'b0;
    illegal_next = 1'b0;
    done_now     = 1'b0;
    instr_ready  = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    alu_op       = ALU_XFER;
    dr_one       = 1'b0;
    alu_wr       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        instr_ready = !halted_reg;
        if (instr_valid && !halted_reg) begin
          ir_next = instr;
          ea_next = instr[AW-1:0];
          case (instr_opc)
            OPC_AND, OPC_ADD, OPC_LDA: state_next = instr[W-1] ? S_IND : S_RD;
            OPC_STA:                   state_next = instr[W-1] ? S_IND : S_WR;
            OPC_REG: begin
              if (!instr[W-1]) begin
                state_next = S_EXEC;
              end else begin
                done_next    = 1'b1;
                illegal_next = 1'b1;
              end
            end
            default: begin
              done_next    = 1'b1;
              illegal_next = 1'b1;
            end
          endcase
        end
      end

      S_IND: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ea_next    = mem_rdata[AW-1:0];
          state_next = (ir_opc == OPC_STA) ? S_WR : S_RD;
        end
      end

      S_RD: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          dr_next    = mem_rdata;
          state_next = S_EXEC;
        end
      end

      S_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          done_now   = 1'b1;
          state_next = S_IDLE;
        end
      end

      S_EXEC: begin
        state_next = S_IDLE;
        done_next  = 1'b1;
        case (ir_opc)
          OPC_AND: begin alu_op = ALU_AND; alu_wr = 1'b1; end
          OPC_ADD: begin alu_op = ALU_ADD; alu_wr = 1'b1; end
          OPC_LDA: begin alu_op = ALU_LDA; alu_wr = 1'b1; end
          OPC_REG: begin
            // Highest set bit wins; lower bits are don't-care.
            casez (ir_reg[11:0])
              12'b1???_????_????: begin alu_op = ALU_CLR; alu_wr = 1'b1; end
              12'b01??_????_????: e_next = 1'b0;
              12'b001?_????_????: begin alu_op = ALU_CMA; alu_wr = 1'b1; end
              12'b0001_????_????: e_next = ~e_reg;
              12'b0000_1???_????: begin alu_op = ALU_CIR; alu_wr = 1'b1; end
              12'b0000_01??_????: begin alu_op = ALU_CIL; alu_wr = 1'b1; end
              12'b0000_001?_????: begin alu_op = ALU_ADD; dr_one = 1'b1; alu_wr = 1'b1; end
              12'b0000_0001_????: skip_next = !ac_reg[W-1];
              12'b0000_0000_1???: skip_next = ac_reg[W-1];
              12'b0000_0000_01??: skip_next = (ac_reg == '0);
              12'b0000_0000_001?: skip_next = !e_reg;
              12'b0000_0000_0001: halted_next = 1'b1;
              default: ;
            endcase
          end
          default: ;
        endcase
        if (alu_wr) begin
          ac_next = alu_out;
          e_next  = alu_e_out;
          z_next  = alu_z;
          n_next  = alu_n;
          c_next  = alu_co;
          v_next  = alu_ovf;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign mem_addr  = ea_reg;
  assign mem_wdata = ac_reg;
  assign alu_ac    = ac_reg;
  assign alu_dr    = dr_one ? {{(W-1){1'b0}}, 1'b1} : dr_reg;
  assign alu_e_in  = e_reg;
  assign ac        = ac_reg;
  assign e         = e_reg;
  assign flag_z    = z_reg;
  assign flag_n    = n_reg;
  assign flag_c    = c_reg;
  assign flag_v    = v_reg;
  // Stores retire in the ack cycle itself; everything else retires one cycle after its update.
  assign done      = done_reg | done_now;
  assign skip      = skip_reg;
  assign illegal   = illegal_reg;
  assign halted    = halted_reg;

endmodule
